// File: rtl/alt_vipvfr131_common_packet_decoder.sv
// Packet decoder for the common stream-input path.
// Classifies each packet by the header nibble of its first beat:
//   type 0x0 : video, payload forwarded downstream with the header stripped
//   type 0xF : control, nine nibbles decoded into width/height/interlace
//   others   : user/unknown, accepted and dropped
// Payload passes combinationally (zero latency); decoded control fields,
// ctrl_valid and sync_error are registered.
module alt_vipvfr131_common_packet_decoder #(
  parameter int          DATA_WIDTH     = 10,
  parameter logic [15:0] DEFAULT_WIDTH  = 16'd1920,
  parameter logic [15:0] DEFAULT_HEIGHT = 16'd1080
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  int_ready,
  input  logic                  int_valid,
  input  logic [DATA_WIDTH-1:0] int_data,
  input  logic                  int_sop,
  input  logic                  int_eop,
  input  logic                  dout_ready,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_sop,
  output logic                  dout_eop,
  output logic [15:0]           ctrl_width,
  output logic [15:0]           ctrl_height,
  output logic [3:0]            ctrl_interlace,
  output logic                  ctrl_valid,
  output logic                  sync_error
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_VIDEO   = 2'd1,
    ST_CTRL    = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  // Number of nibbles that make up a complete control packet body.
  localparam logic [3:0] NIB_FULL = 4'd9;

  state_t      state_r;
  state_t      state_nx_s;
  logic        first_r;
  logic        first_nx_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nx_s;
  logic [15:0] width_sh_r;
  logic [15:0] width_nx_s;
  logic [15:0] height_sh_r;
  logic [15:0] height_nx_s;
  logic [3:0]  ilace_sh_r;
  logic [3:0]  ilace_nx_s;
  logic [15:0] ctrl_width_r;
  logic [15:0] ctrl_height_r;
  logic [3:0]  ctrl_interlace_r;
  logic        ctrl_valid_r;
  logic        sync_error_r;
  logic        commit_s;
  logic        sync_err_s;
  logic        ready_s;
  logic        xfer_s;
  logic        hdr_s;
  logic [3:0]  nib_s;

  assign xfer_s = int_valid && ready_s;
  assign hdr_s  = xfer_s && int_sop;
  assign nib_s  = int_data[3:0];

  // Upstream backpressure: only video payload is throttled by the sink.
  always_comb begin
    ready_s = 1'b1;
    case (state_r)
      ST_VIDEO: ready_s = dout_ready;
      default:  ready_s = 1'b1;
    endcase
  end

  assign int_ready = ready_s;

  // Zero-latency payload path; a sop beat seen in VIDEO is a new header, never payload.
  always_comb begin
    dout_valid = 1'b0;
    dout_data  = int_data;
    dout_sop   = 1'b0;
    dout_eop   = 1'b0;
    if (state_r == ST_VIDEO) begin
      dout_valid = int_valid && !int_sop;
      dout_sop   = int_valid && !int_sop && first_r;
      dout_eop   = int_valid && !int_sop && int_eop;
    end else begin
      dout_valid = 1'b0;
      dout_sop   = 1'b0;
      dout_eop   = 1'b0;
    end
  end

  // Next-state, nibble staging and commit/abort decisions.
  always_comb begin
    state_nx_s  = state_r;
    first_nx_s  = first_r;
    cnt_nx_s    = cnt_r;
    width_nx_s  = width_sh_r;
    height_nx_s = height_sh_r;
    ilace_nx_s  = ilace_sh_r;
    commit_s    = 1'b0;
    sync_err_s  = 1'b0;
    if (hdr_s) begin
      // Any accepted sop beat is a header, whatever state we were in.
      case (nib_s)
        4'h0: begin
          state_nx_s = int_eop ? ST_IDLE : ST_VIDEO;
          first_nx_s = 1'b1;
        end
        4'hF: begin
          state_nx_s = int_eop ? ST_IDLE : ST_CTRL;
          cnt_nx_s   = 4'd0;
        end
        default: begin
          state_nx_s = int_eop ? ST_IDLE : ST_DISCARD;
        end
      endcase
      // Only an interrupted video packet is reported; aborted control is silent.
      if (state_r == ST_VIDEO) begin
        sync_err_s = 1'b1;
      end else begin
        sync_err_s = 1'b0;
      end
    end else if (xfer_s) begin
      case (state_r)
        ST_IDLE: begin
          // Orphan beats (e.g. tail of a packet cut by reset) are dropped.
          state_nx_s = ST_IDLE;
        end
        ST_VIDEO: begin
          first_nx_s = 1'b0;
          if (int_eop) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_VIDEO;
          end
        end
        ST_CTRL: begin
          if (cnt_r < NIB_FULL) begin
            cnt_nx_s = cnt_r + 4'd1;
            case (cnt_r)
              4'd0:    width_nx_s[15:12]  = nib_s;
              4'd1:    width_nx_s[11:8]   = nib_s;
              4'd2:    width_nx_s[7:4]    = nib_s;
              4'd3:    width_nx_s[3:0]    = nib_s;
              4'd4:    height_nx_s[15:12] = nib_s;
              4'd5:    height_nx_s[11:8]  = nib_s;
              4'd6:    height_nx_s[7:4]   = nib_s;
              4'd7:    height_nx_s[3:0]   = nib_s;
              4'd8:    ilace_nx_s         = nib_s;
              default: ilace_nx_s         = ilace_sh_r;
            endcase
          end else begin
            // Saturated: surplus nibbles are ignored.
            cnt_nx_s = cnt_r;
          end
          if (int_eop) begin
            state_nx_s = ST_IDLE;
            commit_s   = (cnt_nx_s >= NIB_FULL);
          end else begin
            state_nx_s = ST_CTRL;
          end
        end
        ST_DISCARD: begin
          if (int_eop) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DISCARD;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end else begin
      // Bubble: hold everything.
      state_nx_s = state_r;
    end
  end

  // State, first-beat flag, nibble counter and shadow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      first_r     <= 1'b0;
      cnt_r       <= 4'd0;
      width_sh_r  <= 16'd0;
      height_sh_r <= 16'd0;
      ilace_sh_r  <= 4'd0;
    end else begin
      state_r     <= state_nx_s;
      first_r     <= first_nx_s;
      cnt_r       <= cnt_nx_s;
      width_sh_r  <= width_nx_s;
      height_sh_r <= height_nx_s;
      ilace_sh_r  <= ilace_nx_s;
    end
  end

  // Committed control fields and the one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_width_r     <= DEFAULT_WIDTH;
      ctrl_height_r    <= DEFAULT_HEIGHT;
      ctrl_interlace_r <= 4'd0;
      ctrl_valid_r     <= 1'b0;
      sync_error_r     <= 1'b0;
    end else begin
      if (commit_s) begin
        ctrl_width_r     <= width_nx_s;
        ctrl_height_r    <= height_nx_s;
        ctrl_interlace_r <= ilace_nx_s;
      end else begin
        ctrl_width_r     <= ctrl_width_r;
        ctrl_height_r    <= ctrl_height_r;
        ctrl_interlace_r <= ctrl_interlace_r;
      end
      ctrl_valid_r <= commit_s;
      sync_error_r <= sync_err_s;
    end
  end

  assign ctrl_width     = ctrl_width_r;
  assign ctrl_height    = ctrl_height_r;
  assign ctrl_interlace = ctrl_interlace_r;
  assign ctrl_valid     = ctrl_valid_r;
  assign sync_error     = sync_error_r;

endmodule

// File: tb/tb_alt_vipvfr131_common_packet_decoder.sv
// Directed self-checking bench for alt_vipvfr131_common_packet_decoder.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_alt_vipvfr131_common_packet_decoder;

  logic        clk;
  logic        rst;
  logic        int_ready;
  logic        int_valid;
  logic [9:0]  int_data;
  logic        int_sop;
  logic        int_eop;
  logic        dout_ready;
  logic        dout_valid;
  logic [9:0]  dout_data;
  logic        dout_sop;
  logic        dout_eop;
  logic [15:0] ctrl_width;
  logic [15:0] ctrl_height;
  logic [3:0]  ctrl_interlace;
  logic        ctrl_valid;
  logic        sync_error;

  int n_cmp = 0;
  int n_err = 0;
  int beats = 0;

  alt_vipvfr131_common_packet_decoder #(
    .DATA_WIDTH(10),
    .DEFAULT_WIDTH(16'd1920),
    .DEFAULT_HEIGHT(16'd1080)
  ) dut (
    .clk(clk), .rst(rst),
    .int_ready(int_ready), .int_valid(int_valid), .int_data(int_data),
    .int_sop(int_sop), .int_eop(int_eop),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_data(dout_data),
    .dout_sop(dout_sop), .dout_eop(dout_eop),
    .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
    .ctrl_interlace(ctrl_interlace), .ctrl_valid(ctrl_valid),
    .sync_error(sync_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus; counts downstream transfers as they are presented.
  task automatic step(input logic r, input logic v, input logic [9:0] d,
                      input logic s, input logic e, input logic rdy);
    @(negedge clk);
    rst        = r;
    int_valid  = v;
    int_data   = d;
    int_sop    = s;
    int_eop    = e;
    dout_ready = rdy;
    #1;
    if (dout_valid === 1'b1 && dout_ready === 1'b1) beats++;
  endtask

  initial begin
    rst = 1'b1; int_valid = 1'b0; int_data = 10'h000;
    int_sop = 1'b0; int_eop = 1'b0; dout_ready = 1'b1;

    // Reset and idle defaults
    step(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("rst_width",  ctrl_width,     32'd1920);
    chk("rst_height", ctrl_height,    32'd1080);
    chk("rst_ilace",  ctrl_interlace, 32'd0);
    chk("rst_dvalid", dout_valid,     32'd0);
    chk("rst_ready",  int_ready,      32'd1);
    chk("rst_cvalid", ctrl_valid,     32'd0);
    chk("rst_syncer", sync_error,     32'd0);

    // Full control packet F,0,7,8,0,0,4,3,8,3 with one bubble
    step(1'b0, 1'b1, 10'h00F, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h007, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h008, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 10'h00A, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h003, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h008, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h003, 1'b0, 1'b1, 1'b1);
    chk("ctl_pre_width", ctrl_width, 32'd1920);
    chk("ctl_pre_cv",    ctrl_valid, 32'd0);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("ctl_cvalid", ctrl_valid,     32'd1);
    chk("ctl_width",  ctrl_width,     32'h0780);
    chk("ctl_height", ctrl_height,    32'h0438);
    chk("ctl_ilace",  ctrl_interlace, 32'd3);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("ctl_cv_drop", ctrl_valid, 32'd0);

    // Video packet with dout_ready toggling
    beats = 0;
    step(1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 1'b1);
    chk("v1_hdr_dv", dout_valid, 32'd0);
    step(1'b0, 1'b1, 10'h011, 1'b0, 1'b0, 1'b1);
    chk("v1_b0_dv",   dout_valid, 32'd1);
    chk("v1_b0_data", dout_data,  32'h011);
    chk("v1_b0_sop",  dout_sop,   32'd1);
    chk("v1_b0_eop",  dout_eop,   32'd0);
    chk("v1_b0_rdy",  int_ready,  32'd1);
    step(1'b0, 1'b1, 10'h022, 1'b0, 1'b0, 1'b0);
    chk("v1_b1w_rdy", int_ready, 32'd0);
    chk("v1_b1w_sop", dout_sop,  32'd0);
    step(1'b0, 1'b1, 10'h022, 1'b0, 1'b0, 1'b1);
    chk("v1_b1_rdy",  int_ready, 32'd1);
    chk("v1_b1_data", dout_data, 32'h022);
    chk("v1_b1_sop",  dout_sop,  32'd0);
    step(1'b0, 1'b1, 10'h033, 1'b0, 1'b1, 1'b0);
    chk("v1_b2w_rdy", int_ready, 32'd0);
    step(1'b0, 1'b1, 10'h033, 1'b0, 1'b1, 1'b1);
    chk("v1_b2_data", dout_data, 32'h033);
    chk("v1_b2_eop",  dout_eop,  32'd1);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0);
    chk("v1_idle_rdy", int_ready,  32'd1);
    chk("v1_idle_dv",  dout_valid, 32'd0);
    chk("v1_beats",    beats,      32'd3);

    // Short control packet: no commit, no pulse
    step(1'b0, 1'b1, 10'h00F, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h001, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h002, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h003, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h004, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("sc_cvalid", ctrl_valid,  32'd0);
    chk("sc_width",  ctrl_width,  32'h0780);
    chk("sc_height", ctrl_height, 32'h0438);
    beats = 0;
    step(1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h0AA, 1'b0, 1'b0, 1'b1);
    chk("v2_b0_data", dout_data, 32'h0AA);
    chk("v2_b0_sop",  dout_sop,  32'd1);
    step(1'b0, 1'b1, 10'h0BB, 1'b0, 1'b1, 1'b1);
    chk("v2_b1_eop",  dout_eop,  32'd1);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("v2_beats", beats, 32'd2);

    // User packet type 5 (4 beats) then 2-beat video packet
    beats = 0;
    step(1'b0, 1'b1, 10'h005, 1'b1, 1'b0, 1'b1);
    chk("u_hdr_dv", dout_valid, 32'd0);
    step(1'b0, 1'b1, 10'h021, 1'b0, 1'b0, 1'b1);
    chk("u_b0_dv", dout_valid, 32'd0);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("u_b1_dv", dout_valid, 32'd0);
    step(1'b0, 1'b1, 10'h023, 1'b0, 1'b1, 1'b1);
    chk("u_b2_dv", dout_valid, 32'd0);
    step(1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h031, 1'b0, 1'b0, 1'b1);
    chk("v3_b0_data", dout_data, 32'h031);
    chk("v3_b0_sop",  dout_sop,  32'd1);
    step(1'b0, 1'b1, 10'h032, 1'b0, 1'b1, 1'b1);
    chk("v3_b1_data", dout_data, 32'h032);
    chk("v3_b1_eop",  dout_eop,  32'd1);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("u_v3_beats", beats, 32'd2);

    // Video aborted by a control header after 2 payload beats
    beats = 0;
    step(1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h101, 1'b0, 1'b0, 1'b1);
    chk("ab_b0_eop", dout_eop, 32'd0);
    step(1'b0, 1'b1, 10'h102, 1'b0, 1'b0, 1'b1);
    chk("ab_b1_eop", dout_eop, 32'd0);
    step(1'b0, 1'b1, 10'h00F, 1'b1, 1'b0, 1'b1);
    chk("ab_hdr_dv",  dout_valid, 32'd0);
    chk("ab_hdr_eop", dout_eop,   32'd0);
    chk("ab_hdr_rdy", int_ready,  32'd1);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("ab_syncer_hi", sync_error, 32'd1);
    step(1'b0, 1'b1, 10'h005, 1'b0, 1'b0, 1'b1);
    chk("ab_syncer_lo", sync_error, 32'd0);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h002, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h00D, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h001, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("ab_beats",  beats,          32'd2);
    chk("ab_cvalid", ctrl_valid,     32'd1);
    chk("ab_width",  ctrl_width,     32'h0500);
    chk("ab_height", ctrl_height,    32'h02D0);
    chk("ab_ilace",  ctrl_interlace, 32'd1);

    // Reset in the middle of a control packet; tail is dropped in IDLE
    step(1'b0, 1'b1, 10'h00F, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h001, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h002, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h003, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h004, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h005, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h006, 1'b0, 1'b0, 1'b1);
    chk("mr_width", ctrl_width, 32'd1920);
    step(1'b0, 1'b1, 10'h007, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h008, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 10'h009, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1);
    chk("mr_cvalid", ctrl_valid,     32'd0);
    chk("mr_width2", ctrl_width,     32'd1920);
    chk("mr_height", ctrl_height,    32'd1080);
    chk("mr_ilace",  ctrl_interlace, 32'd0);
    chk("mr_dv",     dout_valid,     32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alt_vipvfr131_common_packet_decoder.md
Name: alt_vipvfr131_common_packet_decoder

Overview:
- Sits directly downstream of the common stream-input stage and consumes its internal Avalon-ST-style stream (valid/ready/data/sop/eop).
- Classifies each packet by the header nibble in the first beat, and decodes control packets into registered width/height/interlace fields.
- Forwards video-packet payload, with the header beat stripped, to the next stage.
- Discards user and unknown packets.

Parameters:
- DATA_WIDTH, 10, width of the data bus in bits; must be ≥4.
- DEFAULT_WIDTH, 1920, reset value of ctrl_width.
- DEFAULT_HEIGHT, 1080, reset value of ctrl_height.

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- int_ready  out  1  upstream ready; combinational
- int_valid  in  1  upstream beat valid
- int_data  in  DATA_WIDTH  upstream data; header type and control nibbles are in bits [3:0]
- int_sop  in  1  start of packet
- int_eop  in  1  end of packet
- dout_ready  in  1  downstream ready
- dout_valid  out  1  video payload beat valid
- dout_data  out  DATA_WIDTH  video payload data
- dout_sop  out  1  first payload beat of a video packet
- dout_eop  out  1  last payload beat of a video packet
- ctrl_width  out  16  last committed frame width
- ctrl_height  out  16  last committed frame height
- ctrl_interlace  out  4  last committed interlace nibble
- ctrl_valid  out  1  one-cycle pulse after a commit
- sync_error  out  1  one-cycle pulse when a video packet is aborted

Behaviour:
- Handshakes:
  - A beat transfers when int_valid && int_ready.
  - No ready latency; ready is combinational.
  - int_ready = dout_ready in state VIDEO; int_ready = 1 in every other state.
- Reset:
  - state=IDLE; ctrl_width=DEFAULT_WIDTH; ctrl_height=DEFAULT_HEIGHT; ctrl_interlace=0.
  - ctrl_valid=0, sync_error=0, nibble counter=0, first-beat flag=0.
  - Reset mid-packet drops the packet in flight. No partial commit. The remainder of that packet is then discarded in IDLE until a beat with sop arrives.
- State machine:
  - IDLE:
    - Beats without sop are accepted and dropped.
    - A beat with sop is the header, dispatched on type = int_data[3:0]:
      - 0x0 → VIDEO, set the first-beat flag.
      - 0xF → CTRL, clear the nibble counter.
      - any other value → DISCARD.
    - If the header beat also carries eop, stay in IDLE. For type 0 no output is produced; for type 0xF no commit occurs.
  - VIDEO:
    - dout_valid = int_valid; dout_data = int_data; dout_eop = int_eop.
    - dout_sop = int_valid && first-beat flag. The flag clears on the first transfer.
    - A transfer with eop → IDLE.
    - A beat with sop arriving in VIDEO is not forwarded (dout_valid=0 for that beat) and is accepted as a new header, dispatched as in IDLE. sync_error pulses 1 cycle. No eop is fabricated for the aborted packet.
  - CTRL:
    - Each accepted beat supplies one nibble, int_data[3:0], in order: width[15:12], [11:8], [7:4], [3:0]; height[15:12], [11:8], [7:4], [3:0]; interlace[3:0].
    - Nibbles are staged in shadow registers. The counter saturates at 9; nibbles beyond the 9th are ignored.
    - On the eop transfer: if counter (including this beat) ≥ 9, copy shadows to the ctrl_* outputs at that edge and drive ctrl_valid=1 the following cycle; otherwise no update and no pulse. Then → IDLE.
    - A sop beat arriving in CTRL abandons the control packet (no commit, no sync_error) and is dispatched as a new header.
  - DISCARD:
    - All beats are accepted and dropped.
    - eop → IDLE; a sop beat is dispatched as a new header.
- Outputs:
  - dout_valid=0 in every state except VIDEO.
  - The ctrl_* outputs are registered and change only on a commit or on reset.
  - ctrl_valid and sync_error are registered single-cycle pulses.
- Latency and ordering:
  - Payload passes with zero cycles of latency; ctrl_valid follows the eop edge by 1 cycle.
  - Data beat order is preserved.
  - int_valid low inserts bubbles with no state change.

Test Plan:
- Reset, then idle → ctrl_width=1920, ctrl_height=1080, ctrl_interlace=0, dout_valid=0, int_ready=1.
- Control packet of 10 beats with nibbles F,0,7,8,0,0,4,3,8,3 (eop on the last) → ctrl_width=0x0780, ctrl_height=0x0438, ctrl_interlace=3, ctrl_valid high exactly 1 cycle after the eop edge.
- Video packet header 0 then payload 0x11, 0x22, 0x33 (eop), with dout_ready toggling 1,0,1,0 → dout emits exactly 3 beats in order, sop on 0x11, eop on 0x33; int_ready mirrors dout_ready.
- Short control packet F,1,2,3,4 (eop) → no ctrl_* change, no ctrl_valid; a following video packet passes normally.
- User packet type 5 with 4 beats, then video packet type 0 with 2 beats → only the 2 video beats appear on dout.
- Video packet aborted by a sop beat of type F after 2 payload beats → 2 beats forwarded with no eop, sync_error pulses once, and the control packet decodes and commits normally; rst asserted mid-CTRL → defaults retained.
